// File: rtl/unary_pair_tx_12_pkg.sv
// ----------------------------------------------------------------------------
// unary_pair_tx_12_pkg
// Shared definitions for the dual-channel unary pulse transmitter:
//   UNARY_W    - width of each channel's pulse count
//   UNARY_MAX  - largest count a channel can be loaded with
//   count_t    - count type used on the bus and inside the channel counters
//   state_t    - transmitter sequencing states
//   is_last()  - true when a counter is at or below one, i.e. it reads zero
//                once the current cycle's decrement has been applied
// ----------------------------------------------------------------------------
package unary_pair_tx_12_pkg;

   localparam int UNARY_W = 12;

   typedef logic [UNARY_W-1:0] count_t;

   localparam count_t UNARY_MAX = count_t'(4095);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_last(input count_t value);
      return value <= count_t'(1);
   endfunction

endpackage

// File: rtl/unary_pair_tx_12_if.sv
// ----------------------------------------------------------------------------
// unary_pair_tx_12_if
// Bundles the request and stream signals of the unary pair transmitter.
//   load   - start request (master -> slave), honoured only while ready=1
//   din_a  - pulse count for channel A
//   din_b  - pulse count for channel B
//   gap    - 1 = idle cycle between pulse cycles, captured at load
//   en     - 0 = pause the transmitter
//   a_out  - unary stream A (slave -> master)
//   b_out  - unary stream B
//   ready  - transmitter idle and able to take a load
//   done   - single-cycle completion pulse
// Modports: master drives requests, slave (the transmitter) drives streams.
// ----------------------------------------------------------------------------
interface unary_pair_tx_12_if;
   import unary_pair_tx_12_pkg::*;

   logic   load;
   count_t din_a;
   count_t din_b;
   logic   gap;
   logic   en;
   logic   a_out;
   logic   b_out;
   logic   ready;
   logic   done;

   modport master (
      output load, din_a, din_b, gap, en,
      input  a_out, b_out, ready, done
   );

   modport slave (
      input  load, din_a, din_b, gap, en,
      output a_out, b_out, ready, done
   );

endinterface

// File: rtl/unary_chan_12.sv
// ----------------------------------------------------------------------------
// unary_chan_12
// One channel of the unary transmitter: a loadable down-counter that holds
// the number of pulses still owed on this channel.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, clears the count
//   load      - capture load_val into the counter
//   load_val  - pulse count to capture
//   dec       - consume one pulse this cycle (ignored once the count is zero)
//   pulse     - count is non-zero, so this channel owes a pulse this cycle
//   last      - count will be zero after this cycle's decrement
// ----------------------------------------------------------------------------
module unary_chan_12
   import unary_pair_tx_12_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  count_t load_val,
   input  logic   dec,
   output logic   pulse,
   output logic   last
);

   count_t rem_q;
   count_t rem_d;

   // Load wins over decrement; a zero count saturates so a channel that
   // finishes early simply stays quiet while its partner keeps going.
   always_comb begin
      rem_d = rem_q;
      if (load) begin
         rem_d = load_val;
      end else if (dec && (rem_q != '0)) begin
         rem_d = rem_q - count_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign pulse = (rem_q != '0);
   assign last  = is_last(rem_q);

endmodule

// File: rtl/unary_pair_tx_12.sv
// ----------------------------------------------------------------------------
// unary_pair_tx_12
// Dual-channel unary transmitter. A load captures two 12-bit counts and a gap
// option; the block then emits din_a high cycles on a_out and din_b high
// cycles on b_out, both channels starting in the same cycle, optionally with
// an idle cycle between pulse cycles, and finishes with a one-cycle done.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, aborts any transfer silently
//   bus   - unary_pair_tx_12_if slave modport (load/din_a/din_b/gap/en in,
//           a_out/b_out/ready/done out)
// Pulse outputs and done are decoded from registered state and counters and
// gated by en, so a paused cycle shows nothing and consumes nothing.
// ----------------------------------------------------------------------------
module unary_pair_tx_12
   import unary_pair_tx_12_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   unary_pair_tx_12_if.slave  bus
);

   state_t state_q;
   state_t state_d;
   logic   gap_flag_q;
   logic   gap_flag_d;

   logic   chan_load;
   logic   chan_dec;
   logic   pulse_a;
   logic   pulse_b;
   logic   last_a;
   logic   last_b;

   logic   a_out_c;
   logic   b_out_c;
   logic   ready_c;
   logic   done_c;

   unary_chan_12 u_chan_a (
      .clk      (clk),
      .rst      (rst),
      .load     (chan_load),
      .load_val (bus.din_a),
      .dec      (chan_dec),
      .pulse    (pulse_a),
      .last     (last_a)
   );

   unary_chan_12 u_chan_b (
      .clk      (clk),
      .rst      (rst),
      .load     (chan_load),
      .load_val (bus.din_b),
      .dec      (chan_dec),
      .pulse    (pulse_b),
      .last     (last_b)
   );

   // Next-state and output decode. Every state holds still while en=0, which
   // is what freezes the counters and pushes a pending done out to the first
   // enabled cycle.
   always_comb begin
      state_d    = state_q;
      gap_flag_d = gap_flag_q;
      chan_load  = 1'b0;
      chan_dec   = 1'b0;
      a_out_c    = 1'b0;
      b_out_c    = 1'b0;
      done_c     = 1'b0;
      ready_c    = (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (bus.load && bus.en) begin
               chan_load  = 1'b1;
               gap_flag_d = bus.gap;
               // Two zero counts have nothing to send; finish straight away.
               if ((bus.din_a == '0) && (bus.din_b == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = SEND;
               end
            end
         end

         SEND: begin
            if (bus.en) begin
               a_out_c  = pulse_a;
               b_out_c  = pulse_b;
               chan_dec = 1'b1;
               // Finishing is checked before the gap so that no idle cycle
               // trails the final pulse.
               if (last_a && last_b) begin
                  state_d = DONE;
               end else if (gap_flag_q) begin
                  state_d = GAP;
               end
            end
         end

         GAP: begin
            if (bus.en) begin
               state_d = SEND;
            end
         end

         DONE: begin
            if (bus.en) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gap_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_flag_q <= gap_flag_d;
      end
   end

   assign bus.a_out = a_out_c;
   assign bus.b_out = b_out_c;
   assign bus.ready = ready_c;
   assign bus.done  = done_c;

endmodule
